// File: rtl/slice_serializer.sv
// ---------------------------------------------------------------------------
// slice_serializer
//   Converts SLICE_W-bit state slices into an LSB-first serial bit stream.
//   Two storage stages are used: a shift register (SR) that feeds ser_out and
//   a holding register (HR) that lets the next slice wait for the SR.
//   Bits are framed into blocks of SLICES slices with first/last markers.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module slice_serializer #(
  parameter int SLICE_W = 25,
  parameter int SLICES  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [SLICE_W-1:0] in_slice,
  output logic               in_ready,
  input  logic               ser_ready,
  output logic               ser_valid,
  output logic               ser_out,
  output logic               ser_first,
  output logic               ser_last,
  output logic               block_done
);

  localparam int BIT_CW = (SLICE_W > 1) ? $clog2(SLICE_W) : 1;
  localparam int SLC_CW = (SLICES  > 1) ? $clog2(SLICES)  : 1;
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(SLICE_W - 1);
  localparam logic [SLC_CW-1:0] SLC_LAST = SLC_CW'(SLICES - 1);

  // IDLE means the SR is empty, SHIFT means it holds a slice in transit.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state;
  logic [SLICE_W-1:0]  sr;
  logic [SLICE_W-1:0]  hr;
  logic                hr_full;
  logic [BIT_CW-1:0]   bit_cnt;
  logic [SLC_CW-1:0]   slice_cnt;

  logic sr_full;
  logic accept;
  logic xfer;
  logic slice_end;
  logic sr_frees;
  logic block_end;

  // Handshake and framing decode, all derived from registered state.
  assign sr_full    = (state == SHIFT);
  assign in_ready   = !hr_full;
  assign ser_valid  = sr_full;
  assign ser_out    = sr[0];
  assign ser_first  = sr_full && (bit_cnt == '0) && (slice_cnt == '0);
  assign ser_last   = sr_full && (bit_cnt == BIT_LAST) && (slice_cnt == SLC_LAST);

  assign accept     = in_valid && in_ready;
  assign xfer       = ser_valid && ser_ready;
  assign slice_end  = xfer && (bit_cnt == BIT_LAST);
  assign sr_frees   = !sr_full || slice_end;
  assign block_end  = slice_end && (slice_cnt == SLC_LAST);

  // Buffer management, bit/slice counters and the block-done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      hr         <= '0;
      hr_full    <= 1'b0;
      bit_cnt    <= '0;
      slice_cnt  <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= block_end;

      // Counters advance only on an accepted serial bit.
      if (xfer) begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          if (slice_cnt == SLC_LAST) begin
            slice_cnt <= '0;
          end else begin
            slice_cnt <= slice_cnt + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (sr_frees) begin
        if (hr_full) begin
          // The older, waiting slice always goes to the SR first.
          sr    <= hr;
          state <= SHIFT;
          if (accept) begin
            hr <= in_slice;
          end else begin
            hr_full <= 1'b0;
          end
        end else if (accept) begin
          // Straight into the SR: bit 0 is presented the very next cycle.
          sr    <= in_slice;
          state <= SHIFT;
        end else begin
          sr    <= '0;
          state <= IDLE;
        end
      end else begin
        if (xfer) begin
          sr <= sr >> 1;
        end
        if (accept) begin
          hr      <= in_slice;
          hr_full <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slice_serializer.sv
// ---------------------------------------------------------------------------
// tb_slice_serializer
//   Directed bench for slice_serializer: a short vector table for the first
//   cycles after a load, then hand-written sequences checked against a
//   bit-queue scoreboard (expected bits, first/last framing, ready, done).
// ---------------------------------------------------------------------------
`default_nettype none

module tb_slice_serializer;

  localparam int SW  = 25;
  localparam int SN  = 64;
  localparam int BLK = SW * SN;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [SW-1:0] in_slice;
  logic          in_ready;
  logic          ser_ready;
  logic          ser_valid;
  logic          ser_out;
  logic          ser_first;
  logic          ser_last;
  logic          block_done;

  slice_serializer #(.SLICE_W(SW), .SLICES(SN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_slice   (in_slice),
    .in_ready   (in_ready),
    .ser_ready  (ser_ready),
    .ser_valid  (ser_valid),
    .ser_out    (ser_out),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .block_done (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit q[$];
  int tx       = 0;
  int done_cnt = 0;
  bit acc;

  typedef struct {
    logic          iv;
    logic [SW-1:0] sl;
    logic          sr;
    logic [4:0]    exp;   // {in_ready, ser_valid, ser_out, ser_first, ser_last}
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b tx=%0d t=%0t", name, act, exp, tx, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock with scoreboard checks; called #1 after a rising edge.
  task automatic cycle();
    bit xfer;
    bit was_last;
    acc = in_valid && in_ready;
    chk("in_ready", in_ready, q.size() <= SW);
    chk("ser_valid", ser_valid, q.size() != 0);
    if (ser_valid && q.size() != 0) begin
      chk("ser_out", ser_out, q[0]);
      chk("ser_first", ser_first, (tx % BLK) == 0);
      chk("ser_last", ser_last, (tx % BLK) == BLK - 1);
    end
    xfer     = ser_valid && ser_ready && q.size() != 0;
    was_last = xfer && ((tx % BLK) == BLK - 1);
    if (xfer) begin
      void'(q.pop_front());
      tx++;
    end
    if (acc) begin
      for (int i = 0; i < SW; i++) q.push_back(in_slice[i]);
    end
    @(posedge clk);
    #1;
    chk("block_done", block_done, was_last);
    if (block_done) done_cnt++;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_slice  = '0;
    ser_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_ser_first", ser_first, 1'b0);
    chk("rst_ser_last", ser_last, 1'b0);
    chk("rst_block_done", block_done, 1'b0);
    q.delete();
    tx       = 0;
    done_cnt = 0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (q.size() != 0) chk_int("drain_timeout", q.size(), 0);
    cycle();   // ser_valid must be low once the scoreboard is empty
  endtask

  task automatic send_one(input logic [SW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_slice = d;
    acc      = 1'b0;
    while (!acc && n < 200) begin
      cycle();
      n++;
    end
    if (!acc) chk_int("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [SW-1:0] d;
    logic [SW-1:0] b;
    int sent;
    int n;

    vecs[0] = '{1'b1, 25'h1555555, 1'b1, 5'b10000};
    vecs[1] = '{1'b1, 25'h0AAAAAA, 1'b0, 5'b11110};
    vecs[2] = '{1'b0, 25'h0000000, 1'b0, 5'b01110};
    vecs[3] = '{1'b0, 25'h0000000, 1'b1, 5'b01110};
    vecs[4] = '{1'b0, 25'h0000000, 1'b1, 5'b01000};
    vecs[5] = '{1'b0, 25'h0000000, 1'b1, 5'b01100};

    in_valid  = 1'b0;
    in_slice  = '0;
    ser_ready = 1'b1;
    rst       = 1'b1;
    #2;
    do_reset();

    // Vector table: load, hold in HR, stall, then shift the first bits.
    for (int i = 0; i < 6; i++) begin
      in_valid  = vecs[i].iv;
      in_slice  = vecs[i].sl;
      ser_ready = vecs[i].sr;
      checks++;
      if ({in_ready, ser_valid, ser_out, ser_first, ser_last} !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d actual=%b expected=%b", i,
                 {in_ready, ser_valid, ser_out, ser_first, ser_last}, vecs[i].exp);
      end
      @(posedge clk);
      #1;
    end

    // Single slice: 1 then 24 zeros, first marker on bit 0.
    do_reset();
    send_one(25'h0000001);
    drain(100);
    chk_int("single_bits", tx, SW);

    // Full block streamed with in_valid held high.
    do_reset();
    sent = 0;
    n    = 0;
    d    = SW'($urandom);
    while (sent < SN && n < 4000) begin
      in_valid = 1'b1;
      in_slice = d;
      cycle();
      if (acc) begin
        sent++;
        d = SW'($urandom);
      end
      n++;
    end
    in_valid = 1'b0;
    drain(4000);
    chk_int("block_bits", tx, BLK);
    chk_int("block_done_cnt", done_cnt, 1);
    send_one(25'h1ABCDEF);   // new block: ser_first expected again
    drain(100);

    // Three slices back-to-back; in_ready held low while HR waits.
    do_reset();
    send_one(25'h1555555);
    send_one(25'h0AAAAAA);
    send_one(25'h1FFFFFF);
    drain(200);
    chk_int("three_bits", tx, 3 * SW);

    // Downstream stall for 5 cycles on bit 12.
    do_reset();
    d = 25'h1234567;
    send_one(d);
    n = 0;
    while (tx < 12 && n < 100) begin
      cycle();
      n++;
    end
    ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("freeze_bit12", ser_out, d[12]);
    chk_int("freeze_tx", tx, 12);
    ser_ready = 1'b1;
    drain(100);
    chk_int("stall_bits", tx, SW);

    // Reset asserted at bit 10 of slice 30.
    do_reset();
    n = 0;
    d = SW'($urandom);
    while (tx < 30 * SW + 10 && n < 4000) begin
      in_valid = 1'b1;
      in_slice = d;
      cycle();
      if (acc) d = SW'($urandom);
      n++;
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_ser_valid", ser_valid, 1'b0);
    chk("mid_rst_ser_out", ser_out, 1'b0);
    chk("mid_rst_ser_first", ser_first, 1'b0);
    chk("mid_rst_ser_last", ser_last, 1'b0);
    chk("mid_rst_block_done", block_done, 1'b0);
    q.delete();
    tx = 0;
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_one(25'h0F0F0F0);
    chk("post_rst_first", ser_first, 1'b1);
    drain(100);

    // SR empties on the same edge a new slice is accepted into an empty HR.
    do_reset();
    send_one(25'h1FFFFFE);
    n = 0;
    while (tx < SW - 1 && n < 100) begin
      cycle();
      n++;
    end
    b        = 25'h0000003;
    in_valid = 1'b1;
    in_slice = b;
    cycle();
    in_valid = 1'b0;
    chk("no_bubble_valid", ser_valid, 1'b1);
    chk("no_bubble_bit0", ser_out, b[0]);
    drain(100);
    chk_int("no_bubble_bits", tx, 2 * SW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
